// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller slice.
package elevator_pkg;

  localparam int unsigned FLOOR_W            = 5;
  localparam int unsigned FLOOR_MIN          = 1;
  localparam int unsigned NUM_FLOORS_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Up-counter that pulses done on its last tick and restarts from zero.
module elevator_timer #(
  parameter int unsigned TICKS = 4,
  parameter int unsigned W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  logic [W-1:0] cnt;

  assign done = en && (cnt == W'(TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-scheduled elevator controller: latches calls, times travel and door dwell,
// and reports the current floor to the display stage.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS      = NUM_FLOORS_DEFAULT,
  parameter int unsigned TICKS_PER_FLOOR = 50_000_000,
  parameter int unsigned DOOR_TICKS      = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TIMER_W = $clog2(max_u(TICKS_PER_FLOOR, DOOR_TICKS) + 1);

  state_e                  state;
  logic [NUM_FLOORS-1:0]   eff, cur_bit, nxt_bit, clr_mask;
  logic [FLOOR_W-1:0]      nxt_floor;
  logic                    above, below, here, here_nxt, ahead_nxt;
  logic                    in_move, in_door, travel_done, door_done;

  assign in_move   = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign in_door   = (state == DOOR_OPEN);
  assign eff       = pending | req;
  assign nxt_floor = (state == MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);

  // Call scan relative to the current floor and to the floor reached at terminal count.
  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    ahead_nxt = 1'b0;
    cur_bit   = '0;
    nxt_bit   = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      cur_bit[i] = (i + 1 == int'(floor));
      nxt_bit[i] = (i + 1 == int'(nxt_floor));
      if (eff[i] && (i + 1 > int'(floor))) above = 1'b1;
      if (eff[i] && (i + 1 < int'(floor))) below = 1'b1;
      if (eff[i] && ((state == MOVE_DOWN) ? (i + 1 < int'(nxt_floor))
                                          : (i + 1 > int'(nxt_floor)))) ahead_nxt = 1'b1;
    end
  end

  assign here     = |(eff & cur_bit);
  assign here_nxt = |(eff & nxt_bit);

  // Door state keeps clearing the current floor so repeat presses are absorbed.
  always_comb begin
    clr_mask = '0;
    case (state)
      IDLE:              if (here) clr_mask = cur_bit;
      MOVE_UP, MOVE_DOWN: if (travel_done && here_nxt) clr_mask = nxt_bit;
      DOOR_OPEN:         clr_mask = cur_bit;
      default:           clr_mask = '0;
    endcase
  end

  elevator_timer #(
    .TICKS (TICKS_PER_FLOOR),
    .W     (TIMER_W)
  ) u_travel_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (in_move),
    .clr  (!in_move),
    .done (travel_done)
  );

  elevator_timer #(
    .TICKS (DOOR_TICKS),
    .W     (TIMER_W)
  ) u_door_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (in_door),
    .clr  (!in_door),
    .done (door_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      floor     <= FLOOR_W'(FLOOR_MIN);
      door_open <= 1'b0;
      moving    <= 1'b0;
      dir_up    <= 1'b1;
      pending   <= '0;
    end else begin
      pending <= eff & ~clr_mask;
      case (state)
        IDLE: begin
          if (here) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
          end else if (above && (dir_up || !below)) begin
            state  <= MOVE_UP;
            moving <= 1'b1;
            dir_up <= 1'b1;
          end else if (below) begin
            state  <= MOVE_DOWN;
            moving <= 1'b1;
            dir_up <= 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (travel_done) begin
            floor <= nxt_floor;
            if (here_nxt) begin
              state     <= DOOR_OPEN;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (!ahead_nxt) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end
        DOOR_OPEN: begin
          if (door_done) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed scenarios plus random calls, checked every cycle against a countdown-based model.
module tb_elevator_ctrl;

  localparam int TPF  = 4;
  localparam int DOOR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] req = '0;
  logic [4:0] floor;
  logic       door_open, moving, dir_up;
  logic [8:0] pending;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  elevator_ctrl #(
    .NUM_FLOORS      (9),
    .TICKS_PER_FLOOR (TPF),
    .DOOR_TICKS      (DOOR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .floor     (floor),
    .door_open (door_open),
    .moving    (moving),
    .dir_up    (dir_up),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: activity kind plus cycles remaining in it.
  localparam int K_REST = 0, K_RISE = 1, K_FALL = 2, K_DWELL = 3;
  int         m_floor = 1;
  int         m_dir   = 1;
  int         m_kind  = K_REST;
  int         m_left  = 0;
  logic [8:0] m_pend  = '0;

  function automatic bit calls_in(input logic [8:0] v, input int lo, input int hi);
    for (int f = lo; f <= hi; f++) if (f >= 1 && f <= 9 && v[f-1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [8:0] rq);
    logic [8:0] e;
    e = m_pend | rq;
    case (m_kind)
      K_REST: begin
        if (e[m_floor-1]) begin
          e[m_floor-1] = 1'b0;
          m_kind = K_DWELL;
          m_left = DOOR;
        end else if (calls_in(e, m_floor + 1, 9) && (m_dir == 1 || !calls_in(e, 1, m_floor - 1))) begin
          m_kind = K_RISE; m_dir = 1; m_left = TPF;
        end else if (calls_in(e, 1, m_floor - 1)) begin
          m_kind = K_FALL; m_dir = 0; m_left = TPF;
        end
      end
      K_RISE, K_FALL: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_kind == K_RISE) ? 1 : -1;
          if (e[m_floor-1]) begin
            e[m_floor-1] = 1'b0;
            m_kind = K_DWELL;
            m_left = DOOR;
          end else if ((m_kind == K_RISE) ? calls_in(e, m_floor + 1, 9)
                                          : calls_in(e, 1, m_floor - 1)) begin
            m_left = TPF;
          end else begin
            m_kind = K_REST;
          end
        end
      end
      default: begin
        e[m_floor-1] = 1'b0;
        m_left--;
        if (m_left == 0) m_kind = K_REST;
      end
    endcase
    m_pend = e;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_floor = 1; m_dir = 1; m_kind = K_REST; m_left = 0; m_pend = '0;
    end else begin
      model_step(req);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_eq("floor", 32'(floor), 32'(m_floor));
      check_eq("door_open", 32'(door_open), 32'(m_kind == K_DWELL));
      check_eq("moving", 32'(moving), 32'(m_kind == K_RISE || m_kind == K_FALL));
      check_eq("dir_up", 32'(dir_up), 32'(m_dir));
      check_eq("pending", 32'(pending), 32'(m_pend));
      check_eq("floor_range", 32'(floor >= 5'd1 && floor <= 5'd9), 32'd1);
    end
  end

  task automatic pulse(input logic [8:0] mask);
    @(negedge clk);
    req = mask;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (!(door_open == 1'b0 && moving == 1'b0 && pending == '0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_bound"}, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_floor(input string tag, input int f, input int budget);
    int k = 0;
    while (int'(floor) != f && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_bound"}, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_door(input string tag, input int budget);
    int k = 0;
    while (!door_open && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_bound"}, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int n;
    // 1: reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_floor", 32'(floor), 32'd1);
    check_eq("rst_door", 32'(door_open), 32'd0);
    check_eq("rst_moving", 32'(moving), 32'd0);
    check_eq("rst_dir", 32'(dir_up), 32'd1);
    check_eq("rst_pending", 32'(pending), 32'd0);
    cmp_en = 1'b1;
    rst = 1'b0;

    // 2: call at current floor opens the door for DOOR cycles
    pulse(9'h001);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (door_open) n++;
      @(negedge clk);
    end
    check_eq("t2_door_cycles", 32'(n), 32'(DOOR));
    check_eq("t2_pending", 32'(pending), 32'd0);
    check_eq("t2_floor", 32'(floor), 32'd1);

    // 3: floor 1 -> 4 arrives TPF*3 edges after move start
    pulse(9'h008);
    check_eq("t3_moving", 32'(moving), 32'd1);
    n = 0;
    while (floor != 5'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_latency", 32'(n), 32'(3 * TPF));
    check_eq("t3_door", 32'(door_open), 32'd1);
    check_eq("t3_pend3", 32'(pending[3]), 32'd0);
    wait_idle("t3_idle", 100);

    // 4: going to 8, calls for 7 and 3 while past 5
    pulse(9'h080);
    wait_floor("t4_at6", 6, 100);
    pulse(9'h044);
    wait_door("t4_door7", 100);
    check_eq("t4_stop7", 32'(floor), 32'd7);
    wait_floor("t4_at8", 8, 100);
    check_eq("t4_door8", 32'(door_open), 32'd1);
    wait_idle("t4_idle", 200);
    check_eq("t4_floor3", 32'(floor), 32'd3);
    check_eq("t4_dir_down", 32'(dir_up), 32'd0);

    // 5: idle at 5 heading up, calls 9 and 1 together
    pulse(9'h010);
    wait_idle("t5_pre", 100);
    check_eq("t5_at5", 32'(floor), 32'd5);
    check_eq("t5_dir_up", 32'(dir_up), 32'd1);
    pulse(9'h101);
    wait_door("t5_door", 100);
    check_eq("t5_first9", 32'(floor), 32'd9);
    wait_idle("t5_idle", 300);
    check_eq("t5_then1", 32'(floor), 32'd1);

    // 6: reset mid-travel
    pulse(9'h1F0);
    wait_floor("t6_at3", 3, 100);
    check_eq("t6_pending", 32'(pending), 32'h1F0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_floor", 32'(floor), 32'd1);
    check_eq("t6_pending0", 32'(pending), 32'd0);
    check_eq("t6_moving", 32'(moving), 32'd0);
    check_eq("t6_door", 32'(door_open), 32'd0);
    rst = 1'b0;

    // Random calls with occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      req = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'h000;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    wait_idle("rand_drain", 400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
